// File: rtl/c5_negate_arb.sv
// c5_negate_arb: arbiter sharing one c5_negate datapath among N_REQ valid/ready requesters.
// Macro C5_NEGATE_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.

// c5_negate: wrap-around two's-complement negation with no overflow flag.
module c5_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = {WIDTH{1'b0}} - a_i;
endmodule

module c5_negate_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   I_clk,
    input  logic                   I_reset,
    input  logic [N_REQ-1:0]       I_req_valid,
    input  logic [N_REQ*WIDTH-1:0] I_req_data,
    output logic [N_REQ-1:0]       O_req_ready,
    output logic                   O_rsp_valid,
    output logic [WIDTH-1:0]       O_rsp_data,
    output logic [ID_W-1:0]        O_rsp_id,
    input  logic                   I_rsp_ready
);
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d, operand, negated;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d, gnt_idx, scan_idx;
    logic             found, slot_free, grant;
`ifdef C5_NEGATE_ARB_RR_EN
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    assign slot_free = !rsp_valid_q || I_rsp_ready;

    // Find the first valid requester, scanning upward with wrap from the priority start point.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef C5_NEGATE_ARB_RR_EN
            scan_idx = rr_ptr_q + ID_W'(k);
`else
            scan_idx = ID_W'(k);
`endif
            if (!found && I_req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign grant       = found && slot_free && !I_reset;
    assign O_req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;
    assign operand     = I_req_data[gnt_idx*WIDTH +: WIDTH];

    c5_negate #(.WIDTH(WIDTH)) u_negate (.a_i(operand), .y_o(negated));

    // Result slot loads on a grant, drains when accepted, otherwise holds.
    always_comb begin
        rsp_valid_d = grant || (rsp_valid_q && !I_rsp_ready);
        rsp_data_d  = grant ? negated : rsp_data_q;
        rsp_id_d    = grant ? gnt_idx : rsp_id_q;
`ifdef C5_NEGATE_ARB_RR_EN
        rr_ptr_d    = grant ? gnt_idx + ID_W'(1) : rr_ptr_q;
`endif
    end

    // Result register and arbitration pointer; reset discards any held result.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
`ifdef C5_NEGATE_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef C5_NEGATE_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign O_rsp_valid = rsp_valid_q;
    assign O_rsp_data  = rsp_data_q;
    assign O_rsp_id    = rsp_id_q;
endmodule
